// File: rtl/adder_stim_pkg.sv
// Shared types and the Johnson-ring step used by the adder operand generator.
package adder_stim_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    // {~p[s-1:0], p[w-1:s]}: the ring is unrolled to {~p, p} and shifted right by s.
    function automatic logic [MAX_W-1:0] johnson_step(input logic [MAX_W-1:0] p,
                                                      input int unsigned w,
                                                      input int unsigned s);
        logic [2*MAX_W-1:0] ext;
        logic [2*MAX_W-1:0] mask;
        logic [2*MAX_W-1:0] ring;
        ext  = {{MAX_W{1'b0}}, p};
        mask = ({{(2*MAX_W-1){1'b0}}, 1'b1} << w) - 1;
        ring = (((~ext) & mask) << w) | (ext & mask);
        ring = ring >> s;
        return ring[MAX_W-1:0] & mask[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/adder_stim_pattern.sv
// W-bit Johnson pattern register: reloads the first flit of a packet or advances one flit.
module adder_stim_pattern
    import adder_stim_pkg::*;
#(
    parameter int W = 52,
    parameter int S = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_to_first,
    input  logic         advance,
    output logic [W-1:0] pattern
);

    localparam logic [W-1:0] FIRST_FLIT = W'(johnson_step('0, W, S));

    logic [W-1:0] r_pattern;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
        end else if (clear_to_first) begin
            r_pattern <= FIRST_FLIT;
        end else if (advance) begin
            r_pattern <= W'(johnson_step(MAX_W'(r_pattern), W, S));
        end
    end

    assign pattern = r_pattern;

endmodule

// File: rtl/adder_stim_gen.sv
// Packetized Johnson-pattern operand source feeding the adder's two inputs.
module adder_stim_gen
    import adder_stim_pkg::*;
#(
    parameter int N         = 26,
    parameter int PAYLOAD   = 20,
    parameter int GAP       = 7,
    parameter int NUM_PKTS  = 10,
    parameter int STEP_BITS = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  operand_a,
    output logic [N-1:0]  operand_b,
    output logic          flit_first,
    output logic          flit_last,
    output logic          busy,
    output logic          done,
    output logic [15:0]   pkt_cnt
);

    localparam int W     = 2 * N;
    localparam int IDX_W = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PAYLOAD - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0]      PKTS_TARGET = 16'(NUM_PKTS);

    state_t             r_state;
    logic [IDX_W-1:0]   r_flit_idx;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [15:0]        r_pkt_cnt;
    logic               r_done;
    logic               r_valid;
    logic               r_first;
    logic               r_last;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [15:0]        w_pkt_nxt;
    logic [15:0]        w_pkt_inc;
    logic               w_done_nxt;
    logic               w_clear;
    logic               w_advance;
    logic [W-1:0]       w_pattern;

    adder_stim_pattern #(
        .W (W),
        .S (STEP_BITS)
    ) u_pattern (
        .clk            (clk),
        .rst            (rst),
        .clear_to_first (w_clear),
        .advance        (w_advance),
        .pattern        (w_pattern)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_flit_idx;
        w_gap_nxt   = r_gap_cnt;
        w_pkt_nxt   = r_pkt_cnt;
        w_done_nxt  = r_done;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_pkt_inc   = r_pkt_cnt + 16'd1;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SEND;
                    w_clear     = 1'b1;
                    w_idx_nxt   = '0;
                    w_pkt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            ST_SEND: begin
                if (r_valid && out_ready) begin
                    if (r_flit_idx != LAST_IDX) begin
                        w_advance = 1'b1;
                        w_idx_nxt = r_flit_idx + IDX_W'(1);
                    end else begin
                        w_pkt_nxt = w_pkt_inc;
                        // NUM_PKTS of zero means an endless run, so the wrap to 0 never ends it.
                        if (NUM_PKTS != 0 && w_pkt_inc == PKTS_TARGET) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else if (GAP == 0) begin
                            w_clear   = 1'b1;
                            w_idx_nxt = '0;
                        end else begin
                            w_state_nxt = ST_GAP;
                            w_gap_nxt   = GAP_LOAD;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_SEND;
                    w_clear     = 1'b1;
                    w_idx_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Flag outputs are registered from next-state values so nothing combinational reaches a port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_flit_idx <= '0;
            r_gap_cnt  <= '0;
            r_pkt_cnt  <= '0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_flit_idx <= w_idx_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_pkt_cnt  <= w_pkt_nxt;
            r_done     <= w_done_nxt;
            r_valid    <= (w_state_nxt == ST_SEND);
            r_first    <= (w_state_nxt == ST_SEND) && (w_idx_nxt == '0);
            r_last     <= (w_state_nxt == ST_SEND) && (w_idx_nxt == LAST_IDX);
            r_busy     <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_GAP);
        end
    end

    assign out_valid  = r_valid;
    assign operand_a  = w_pattern[N-1:0];
    assign operand_b  = w_pattern[W-1:N];
    assign flit_first = r_first;
    assign flit_last  = r_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pkt_cnt    = r_pkt_cnt;

endmodule
